// File: rtl/eve_pkg.sv
// ---------------------------------------------------------------------------
// eve_pkg
// Shared definitions for the evolution-PE sequencer:
//   - eve_state_t : sequencer FSM state encoding
//   - ZERO_GENE   : empty gene fed for out-of-range parent beats and bubbles
//   - LFSR_POLY / LFSR_SEED and lfsr_next() for the optional random source
// ---------------------------------------------------------------------------
package eve_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_PASS0  = 3'd2,
        S_DRAIN0 = 3'd3,
        S_PASS1  = 3'd4,
        S_DRAIN1 = 3'd5,
        S_FLUSH  = 3'd6,
        S_DONE   = 3'd7
    } eve_state_t;

    localparam logic [63:0] ZERO_GENE = 64'h0;

    // Right-shifting Galois form of x^64+x^63+x^61+x^60+1.
    localparam logic [63:0] LFSR_POLY = 64'hD800_0000_0000_0000;
    localparam logic [63:0] LFSR_SEED = 64'h1;

    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/eve_pack_fifo.sv
// ---------------------------------------------------------------------------
// eve_pack_fifo
// Packing FIFO: up to three writes per cycle (lanes compacted in order
// d1, d2, d3 -- only the valid ones), one read per cycle.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   i_push_vld[2:0]   : per-lane push strobes
//   i_d1..i_d3        : lane data
//   i_pop             : pop the head entry (ignored when empty)
//   o_head            : head entry
//   o_empty           : no entries stored
//   o_free            : free entries
// The caller guarantees pushes never exceed o_free.
// ---------------------------------------------------------------------------
module eve_pack_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 i_push_vld,
    input  logic [W-1:0]               i_d1,
    input  logic [W-1:0]               i_d2,
    input  logic [W-1:0]               i_d3,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_free
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic [1:0]    w_off2;
    logic [1:0]    w_off3;
    logic [1:0]    w_npush;
    logic          w_pop;

    // Slot offset of each lane = number of valid lanes before it.
    always_comb begin
        w_off2  = {1'b0, i_push_vld[0]};
        w_off3  = w_off2 + {1'b0, i_push_vld[1]};
        w_npush = w_off3 + {1'b0, i_push_vld[2]};
    end

    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_count == '0);
    assign o_free  = (PW+1)'(DEPTH) - r_count;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (i_push_vld[0]) r_mem[r_wr_ptr] <= i_d1;
        if (i_push_vld[1]) r_mem[r_wr_ptr + PW'(w_off2)] <= i_d2;
        if (i_push_vld[2]) r_mem[r_wr_ptr + PW'(w_off3)] <= i_d3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_npush);
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count  <= r_count + (PW+1)'(w_npush) - (PW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/eve_sched.sv
// ---------------------------------------------------------------------------
// eve_sched
// Sequencer and output collector for one evolution PE. On start: one setup
// cycle loads the probability word, pass 0 streams both parents with
// pe_state=0 (outputs discarded), pass 1 streams them again with pe_state=1
// and packs the PE's 0..3 output genes per beat into the child memory port.
//
// Optional feature macro: EVE_SCHED_LFSR_EN
//   defined   : internal 64-bit Galois LFSR drives pe_random
//   undefined : i_ext_random port exists and drives pe_random directly
//
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   i_start                      : begin a job (ignored while busy)
//   i_cfg_word                   : probability word (sampled at start)
//   i_p1_len, i_p2_len           : parent gene counts (sampled at start)
//   o_pX_rd_en/_addr, i_pX_rd_data : parent memory reads, 1-cycle latency
//   o_pe_setup, o_pe_state       : PE control
//   o_pe_data_in1/2, o_pe_random : PE inputs
//   i_pe_gene_out1..3, i_pe_out_valid : PE outputs
//   o_ch_wr_en/_addr/_data, i_ch_wr_ready : child memory write port
//   o_busy, o_done, o_child_len  : job status
//   i_ext_random                 : external random pack (macro undefined)
// ---------------------------------------------------------------------------
module eve_sched
    import eve_pkg::*;
#(
    parameter int GENE_SZ    = 64,
    parameter int ADDR_SZ    = 10,
    parameter int PE_LAT     = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [GENE_SZ-1:0] i_cfg_word,
    input  logic [ADDR_SZ-1:0] i_p1_len,
    input  logic [ADDR_SZ-1:0] i_p2_len,
    output logic               o_p1_rd_en,
    output logic               o_p2_rd_en,
    output logic [ADDR_SZ-1:0] o_p1_rd_addr,
    output logic [ADDR_SZ-1:0] o_p2_rd_addr,
    input  logic [GENE_SZ-1:0] i_p1_rd_data,
    input  logic [GENE_SZ-1:0] i_p2_rd_data,
    output logic               o_pe_setup,
    output logic               o_pe_state,
    output logic [GENE_SZ-1:0] o_pe_data_in1,
    output logic [GENE_SZ-1:0] o_pe_data_in2,
    output logic [GENE_SZ-1:0] o_pe_random,
    input  logic [GENE_SZ-1:0] i_pe_gene_out1,
    input  logic [GENE_SZ-1:0] i_pe_gene_out2,
    input  logic [GENE_SZ-1:0] i_pe_gene_out3,
    input  logic [2:0]         i_pe_out_valid,
    output logic               o_ch_wr_en,
    output logic [ADDR_SZ-1:0] o_ch_wr_addr,
    output logic [GENE_SZ-1:0] o_ch_wr_data,
    input  logic               i_ch_wr_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic [ADDR_SZ-1:0] o_child_len
`ifndef EVE_SCHED_LFSR_EN
    ,
    input  logic [GENE_SZ-1:0] i_ext_random
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    eve_state_t          r_state;
    eve_state_t          w_state_next;
    logic [ADDR_SZ-1:0]  r_n;
    logic [ADDR_SZ-1:0]  r_p1_len;
    logic [ADDR_SZ-1:0]  r_p2_len;
    logic [ADDR_SZ-1:0]  r_beat;
    logic [ADDR_SZ-1:0]  r_wr_addr;
    logic [ADDR_SZ-1:0]  r_child_len;
    logic [GENE_SZ-1:0]  r_cfg;
    logic [PE_LAT:0]     r_vsr;     // bit 0: beat data at PE now; bit PE_LAT: its outputs due
    logic                r_p1_v;
    logic                r_p2_v;

    logic                w_start;
    logic                w_issue;
    logic                w_last;
    logic                w_room;
    logic                w_p1_rd;
    logic                w_p2_rd;
    logic                w_pass1;
    logic                w_accept;
    logic                w_pop;
    logic                w_fifo_empty;
    logic [2:0]          w_push_vld;
    logic [CNT_W-1:0]    w_free;
    logic [GENE_SZ-1:0]  w_fifo_head;
    int                  w_inflight;

    assign w_start = (r_state == S_IDLE) && i_start;
    assign w_last  = (r_beat == r_n - 1'b1);
    assign w_pass1 = (r_state == S_PASS1) || (r_state == S_DRAIN1);

    // Every beat already in flight may still push three genes, so reserve
    // room for all of them plus the candidate beat before issuing.
    always_comb begin
        w_inflight = $countones(r_vsr);
        w_room     = (int'(w_free) >= 3 * (w_inflight + 1));
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE:   if (i_start) w_state_next = S_SETUP;
            S_SETUP:  w_state_next = (r_n == '0) ? S_DONE : S_PASS0;
            S_PASS0: begin
                w_issue = 1'b1;
                if (w_last) w_state_next = S_DRAIN0;
            end
            // Leave once only the final tap is set: that beat completes now.
            S_DRAIN0: if (r_vsr[PE_LAT-1:0] == '0) w_state_next = S_PASS1;
            S_PASS1: begin
                w_issue = w_room;
                if (w_room && w_last) w_state_next = S_DRAIN1;
            end
            S_DRAIN1: if (r_vsr[PE_LAT-1:0] == '0) w_state_next = S_FLUSH;
            S_FLUSH:  if (w_fifo_empty) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    assign w_p1_rd      = w_issue && (r_beat < r_p1_len);
    assign w_p2_rd      = w_issue && (r_beat < r_p2_len);
    assign o_p1_rd_en   = w_p1_rd;
    assign o_p2_rd_en   = w_p2_rd;
    assign o_p1_rd_addr = r_beat;
    assign o_p2_rd_addr = r_beat;

    assign o_pe_setup    = (r_state == S_SETUP);
    assign o_pe_state    = w_pass1;
    assign o_pe_data_in1 = r_p1_v ? i_p1_rd_data : GENE_SZ'(ZERO_GENE);
    assign o_pe_data_in2 = (r_state == S_SETUP) ? r_cfg :
                           (r_p2_v ? i_p2_rd_data : GENE_SZ'(ZERO_GENE));

    assign w_accept   = r_vsr[PE_LAT] && w_pass1;
    assign w_push_vld = w_accept ? i_pe_out_valid : 3'b000;
    assign w_pop      = i_ch_wr_ready && !w_fifo_empty;

    assign o_ch_wr_en   = w_pop;
    assign o_ch_wr_addr = r_wr_addr;
    assign o_ch_wr_data = w_fifo_head;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_child_len  = r_child_len;

    eve_pack_fifo #(
        .W     (GENE_SZ),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push_vld (w_push_vld),
        .i_d1       (i_pe_gene_out1),
        .i_d2       (i_pe_gene_out2),
        .i_d3       (i_pe_gene_out3),
        .i_pop      (w_pop),
        .o_head     (w_fifo_head),
        .o_empty    (w_fifo_empty),
        .o_free     (w_free)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_p1_len    <= '0;
            r_p2_len    <= '0;
            r_beat      <= '0;
            r_wr_addr   <= '0;
            r_child_len <= '0;
            r_cfg       <= '0;
            r_vsr       <= '0;
            r_p1_v      <= 1'b0;
            r_p2_v      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_vsr   <= {r_vsr[PE_LAT-1:0], w_issue};
            r_p1_v  <= w_p1_rd;
            r_p2_v  <= w_p2_rd;
            if (w_start) begin
                r_cfg       <= i_cfg_word;
                r_p1_len    <= i_p1_len;
                r_p2_len    <= i_p2_len;
                r_n         <= (i_p1_len > i_p2_len) ? i_p1_len : i_p2_len;
                r_beat      <= '0;
                r_wr_addr   <= '0;
                r_child_len <= '0;
            end else begin
                // Beat counter rewinds after the last beat so pass 1 restarts at 0.
                if (w_issue) r_beat <= w_last ? '0 : r_beat + 1'b1;
                if (w_pop)   r_wr_addr <= r_wr_addr + 1'b1;
                // FIFO is empty on entry to DONE, so the write count is final.
                if (w_state_next == S_DONE && r_state != S_DONE)
                    r_child_len <= r_wr_addr;
            end
        end
    end

`ifdef EVE_SCHED_LFSR_EN
    logic [63:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_lfsr <= LFSR_SEED;
        else if (w_start) r_lfsr <= {i_cfg_word[63:40], 40'h1};
        else if (w_issue) r_lfsr <= lfsr_next(r_lfsr);
    end

    assign o_pe_random = GENE_SZ'(r_lfsr);
`else
    assign o_pe_random = i_ext_random;
`endif

endmodule

// File: tb/tb_eve_sched.sv
module tb_eve_sched;
    localparam int GENE_SZ    = 64;
    localparam int ADDR_SZ    = 10;
    localparam int PE_LAT     = 2;
    localparam int FIFO_DEPTH = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [63:0]        cfg_word;
    logic [ADDR_SZ-1:0] p1_len, p2_len;
    logic               p1_rd_en, p2_rd_en;
    logic [ADDR_SZ-1:0] p1_rd_addr, p2_rd_addr;
    logic [63:0]        p1_rd_data, p2_rd_data;
    logic               pe_setup, pe_state;
    logic [63:0]        pe_data_in1, pe_data_in2, pe_random;
    logic [63:0]        pe_gene_out1, pe_gene_out2, pe_gene_out3;
    logic [2:0]         pe_out_valid;
    logic               ch_wr_en;
    logic [ADDR_SZ-1:0] ch_wr_addr;
    logic [63:0]        ch_wr_data;
    logic               ch_wr_ready;
    logic               busy, done;
    logic [ADDR_SZ-1:0] child_len;
`ifndef EVE_SCHED_LFSR_EN
    logic [63:0]        ext_random = 64'h5A5A_1234_C3C3_8765;
`endif

    always #5 clk = ~clk;

    eve_sched #(
        .GENE_SZ(GENE_SZ), .ADDR_SZ(ADDR_SZ), .PE_LAT(PE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_cfg_word(cfg_word),
        .i_p1_len(p1_len), .i_p2_len(p2_len),
        .o_p1_rd_en(p1_rd_en), .o_p2_rd_en(p2_rd_en),
        .o_p1_rd_addr(p1_rd_addr), .o_p2_rd_addr(p2_rd_addr),
        .i_p1_rd_data(p1_rd_data), .i_p2_rd_data(p2_rd_data),
        .o_pe_setup(pe_setup), .o_pe_state(pe_state),
        .o_pe_data_in1(pe_data_in1), .o_pe_data_in2(pe_data_in2), .o_pe_random(pe_random),
        .i_pe_gene_out1(pe_gene_out1), .i_pe_gene_out2(pe_gene_out2),
        .i_pe_gene_out3(pe_gene_out3), .i_pe_out_valid(pe_out_valid),
        .o_ch_wr_en(ch_wr_en), .o_ch_wr_addr(ch_wr_addr), .o_ch_wr_data(ch_wr_data),
        .i_ch_wr_ready(ch_wr_ready),
        .o_busy(busy), .o_done(done), .o_child_len(child_len)
`ifndef EVE_SCHED_LFSR_EN
        , .i_ext_random(ext_random)
`endif
    );

    typedef struct packed {
        logic [ADDR_SZ-1:0] addr;
        logic [63:0]        data;
    } wr_t;

    wr_t  exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_p1a, exp_p2a, rd1_cnt, rd2_cnt, wr_cnt, done_cnt;
    int   cur_p1_len, cur_p2_len;
    logic [63:0] p1_mem [16];
    logic [63:0] p2_mem [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // PE model: outputs are a fixed function of the inputs PE_LAT cycles earlier.
    function automatic logic [63:0] gene_fn(input int k, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        r = (b << k) | (b >> (64 - k));
        return a ^ r ^ (64'h1111 * k);
    endfunction

    logic [127:0] pe_st0, pe_st1;
    logic [2:0]   pe_mask;
    always @(posedge clk) begin
        pe_st1 <= pe_st0;
        pe_st0 <= {pe_data_in1, pe_data_in2};
    end
    assign pe_gene_out1 = gene_fn(1, pe_st1[127:64], pe_st1[63:0]);
    assign pe_gene_out2 = gene_fn(2, pe_st1[127:64], pe_st1[63:0]);
    assign pe_gene_out3 = gene_fn(3, pe_st1[127:64], pe_st1[63:0]);
    assign pe_out_valid = pe_mask;   // asserted every cycle, bubbles and pass 0 included

    // Parent memories; a non-enabled read returns garbage.
    always @(posedge clk) begin
        p1_rd_data <= p1_rd_en ? p1_mem[p1_rd_addr[3:0]] : 64'hBADC_0FFE_E0DD_F00D;
        p2_rd_data <= p2_rd_en ? p2_mem[p2_rd_addr[3:0]] : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (p1_rd_en) begin
                chk("p1_rd_addr", 64'(p1_rd_addr), 64'(exp_p1a));
                rd1_cnt++;
                exp_p1a = (exp_p1a + 1 >= cur_p1_len) ? 0 : exp_p1a + 1;
            end
            if (p2_rd_en) begin
                chk("p2_rd_addr", 64'(p2_rd_addr), 64'(exp_p2a));
                rd2_cnt++;
                exp_p2a = (exp_p2a + 1 >= cur_p2_len) ? 0 : exp_p2a + 1;
            end
            if (ch_wr_en && !ch_wr_ready)
                chk("wr_en_while_not_ready", 64'(ch_wr_en), 64'd0);
            if (ch_wr_en && ch_wr_ready) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(ch_wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("ch_wr_addr", 64'(ch_wr_addr), 64'(e.addr));
                    chk("ch_wr_data", ch_wr_data, e.data);
                end
            end
            if (done) done_cnt++;
        end
    end

`ifdef EVE_SCHED_LFSR_EN
    function automatic logic [63:0] lfsr_model(input logic [63:0] s);
        return s[0] ? ((s >> 1) ^ 64'hD800_0000_0000_0000) : (s >> 1);
    endfunction

    logic [63:0] prev_rnd;
    logic        prev_issue;
    logic        prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst && prev_valid)
            chk("pe_random_step", pe_random, prev_issue ? lfsr_model(prev_rnd) : prev_rnd);
        prev_valid = !rst && busy;
        prev_rnd   = pe_random;
        prev_issue = p1_rd_en | p2_rd_en;
    end
`endif

    task automatic arm_job(input int l1, input int l2, input logic [63:0] cfg, input logic [2:0] mask,
                           input logic rdy, output int nexp);
        int n;
        int idx;
        logic [63:0] a, b;
        n = (l1 > l2) ? l1 : l2;
        @(posedge clk); #1;
        exp_q.delete();
        cur_p1_len = l1; cur_p2_len = l2;
        exp_p1a = 0; exp_p2a = 0; rd1_cnt = 0; rd2_cnt = 0; wr_cnt = 0; done_cnt = 0;
        idx = 0;
        for (int i = 0; i < n; i++) begin
            a = (i < l1) ? p1_mem[i] : 64'h0;
            b = (i < l2) ? p2_mem[i] : 64'h0;
            for (int k = 1; k <= 3; k++) begin
                if (mask[k-1]) begin
                    exp_q.push_back('{addr: ADDR_SZ'(idx), data: gene_fn(k, a, b)});
                    idx++;
                end
            end
        end
        nexp = idx;
        pe_mask = mask; ch_wr_ready = rdy;
        p1_len = ADDR_SZ'(l1); p2_len = ADDR_SZ'(l2); cfg_word = cfg;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;              // T+1: SETUP
        chk("setup_pe_setup", 64'(pe_setup), 64'd1);
        chk("setup_data_in2", pe_data_in2, cfg);
        chk("setup_data_in1", pe_data_in1, 64'd0);
        chk("setup_busy", 64'(busy), 64'd1);
        @(negedge clk);                            // T+2
        if (n == 0) begin
            chk("n0_done_at_T2", 64'(done), 64'd1);
        end else begin
            chk("first_read_at_T2", 64'(p1_rd_en | p2_rd_en), 64'd1);
`ifdef EVE_SCHED_LFSR_EN
            chk("lfsr_first_beat", pe_random, {cfg[63:40], 40'h1});
`endif
        end
    endtask

    task automatic run_job(input int l1, input int l2, input logic [63:0] cfg,
                           input logic [2:0] mask, input int ready_low);
        int nexp;
        int c;
        arm_job(l1, l2, cfg, mask, (ready_low == 0), nexp);
        c = 2;
        while (done_cnt == 0 && c < 3000) begin
            if (c >= ready_low) ch_wr_ready = 1'b1;
            @(negedge clk);
            c++;
        end
        if (c >= 3000) chk("done_timeout", 64'd0, 64'd1);
        repeat (3) @(negedge clk);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("child_len", 64'(child_len), 64'(nexp));
        chk("writes_total", 64'(wr_cnt), 64'(nexp));
        chk("genes_left", 64'(exp_q.size()), 64'd0);
        chk("p1_reads", 64'(rd1_cnt), 64'(2 * l1));
        chk("p2_reads", 64'(rd2_cnt), 64'(2 * l2));
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int nexp;
        int c;
        for (int i = 0; i < 16; i++) begin
            p1_mem[i] = 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h1_0001;
            p2_mem[i] = 64'h5A5A_0000_0000_0000 + 64'(i) * 64'h100;
        end
        rst = 1'b1; start = 1'b0; cfg_word = '0; p1_len = '0; p2_len = '0;
        ch_wr_ready = 1'b1; pe_mask = 3'b000;
        #1;
        chk("rst_ctrl", 64'({busy, done, p1_rd_en, p2_rd_en, pe_setup, pe_state, ch_wr_en}), 64'd0);
        chk("rst_addr", 64'({ch_wr_addr, child_len, p1_rd_addr, p2_rd_addr}), 64'd0);
        chk("rst_pe_data", pe_data_in1 | pe_data_in2, 64'd0);
`ifdef EVE_SCHED_LFSR_EN
        chk("rst_pe_random_seed", pe_random, 64'h1);
`else
        chk("pe_random_passthru", pe_random, ext_random);
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_job(4, 2, 64'h0123_4567_89AB_CDEF, 3'b001, 0);   // lane1 only, zero p2 genes
        run_job(8, 8, 64'h0000_0000_00AB_CDEF, 3'b111, 20);  // stalls on a full FIFO
        run_job(0, 0, 64'hFEED_0000_0000_BEEF, 3'b111, 0);   // empty job
        run_job(5, 3, 64'hC0DE_C0DE_0000_0001, 3'b101, 0);   // lanes 1 and 3

        // Abort in PASS1, then a clean job.
        arm_job(8, 8, 64'h1111_2222_3333_4444, 3'b111, 1'b1, nexp);
        c = 0;
        while (!pe_state && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) chk("pass1_timeout", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("abort_ctrl", 64'({busy, done, p1_rd_en, p2_rd_en, pe_setup, pe_state, ch_wr_en}), 64'd0);
        chk("abort_addr", 64'({ch_wr_addr, child_len, p1_rd_addr, p2_rd_addr}), 64'd0);
        chk("abort_pe_data", pe_data_in1 | pe_data_in2, 64'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        run_job(4, 2, 64'h0123_4567_89AB_CDEF, 3'b011, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
